// File: rtl/bus_arbiter_3b.sv
// Three-unit bus arbiter: urgent-first, round-robin otherwise, bounded hold under
// contention and a one-cycle dead turnaround between owners.
module bus_arbiter_3b #(
    parameter int unsigned MAXHOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] request,
    input  logic [2:0] urgent,
    output logic [2:0] flowvalve,
    output logic [2:0] conflictstatus,
    output logic [2:0] prioritystatus,
    output logic       busbusy,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

    localparam logic [7:0] HOLD_MAX = 8'(MAXHOLD);
    localparam logic [1:0] NO_OWNER = 2'd3;

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       urgent_grant_q, urgent_grant_d;
    logic [1:0] lastowner_q, lastowner_d;
    logic [7:0] holdcount_q, holdcount_d;
    logic [2:0] flowvalve_q, flowvalve_d;
    logic [2:0] conflict_q, conflict_d;
    logic [2:0] priority_q, priority_d;
    logic       busbusy_q, busbusy_d;

    logic [2:0] eu;
    logic [2:0] owner_mask;
    logic [1:0] sel_idx;
    logic       sel_urgent;
    logic       release_c, preempt_c, timeout_c;

    // Scan last+1, last+2, last+3; the nearest requester overwrites farther ones.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = NO_OWNER;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % 3);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    // NOTE: every register is reset here; sequential state uses <= so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= NO_OWNER;
            urgent_grant_q <= 1'b0;
            lastowner_q    <= 2'd2;
            holdcount_q    <= 8'd0;
            flowvalve_q    <= 3'b000;
            conflict_q     <= 3'b000;
            priority_q     <= 3'b000;
            busbusy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            urgent_grant_q <= urgent_grant_d;
            lastowner_q    <= lastowner_d;
            holdcount_q    <= holdcount_d;
            flowvalve_q    <= flowvalve_d;
            conflict_q     <= conflict_d;
            priority_q     <= priority_d;
            busbusy_q      <= busbusy_d;
        end
    end

    // NOTE: each comb output gets a default first so no path infers a latch.
    always_comb begin
        eu          = urgent & request;
        owner_mask  = 3'b001 << owner_q;
        sel_urgent  = |eu;
        if (eu[0])      sel_idx = 2'd0;
        else if (eu[1]) sel_idx = 2'd1;
        else if (eu[2]) sel_idx = 2'd2;
        else            sel_idx = rr_pick(request, lastowner_q);

        release_c = ~|(request & owner_mask);
        preempt_c = !urgent_grant_q && |(eu & ~owner_mask);
        timeout_c = (holdcount_q == HOLD_MAX) && |(request & ~owner_mask);

        state_d        = state_q;
        owner_d        = owner_q;
        urgent_grant_d = urgent_grant_q;
        lastowner_d    = lastowner_q;
        holdcount_d    = holdcount_q;

        case (state_q)
            IDLE, TURN: begin
                if (|request) begin
                    state_d        = GRANT;
                    owner_d        = sel_idx;
                    urgent_grant_d = sel_urgent;
                    lastowner_d    = sel_idx;
                    holdcount_d    = 8'd1;
                end else begin
                    state_d        = IDLE;
                    owner_d        = NO_OWNER;
                    urgent_grant_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_c || preempt_c || timeout_c) begin
                    state_d        = TURN;
                    owner_d        = NO_OWNER;
                    urgent_grant_d = 1'b0;
                end else if (holdcount_q < HOLD_MAX) begin
                    holdcount_d = holdcount_q + 8'd1;
                end
            end
            default: begin
                state_d        = IDLE;
                owner_d        = NO_OWNER;
                urgent_grant_d = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from next state and registered alongside it.
    always_comb begin
        flowvalve_d = 3'b000;
        conflict_d  = 3'b000;
        priority_d  = 3'b000;
        busbusy_d   = 1'b0;
        if (state_d == GRANT) begin
            flowvalve_d = 3'b001 << owner_d;
            busbusy_d   = 1'b1;
            if (urgent_grant_d) priority_d = 3'b001 << owner_d;
            else                conflict_d = 3'b001 << owner_d;
        end
    end

    assign flowvalve      = flowvalve_q;
    assign conflictstatus = conflict_q;
    assign prioritystatus = priority_q;
    assign busbusy        = busbusy_q;
    assign owner          = owner_q;

endmodule

// File: tb/tb_bus_arbiter_3b.sv
// Directed bench for bus_arbiter_3b with MAXHOLD=4; outputs are sampled on the
// falling edge and inputs are changed right after sampling.
module tb_bus_arbiter_3b;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] request;
    logic [2:0] urgent;
    logic [2:0] flowvalve;
    logic [2:0] conflictstatus;
    logic [2:0] prioritystatus;
    logic       busbusy;
    logic [1:0] owner;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter_3b #(.MAXHOLD(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .request        (request),
        .urgent         (urgent),
        .flowvalve      (flowvalve),
        .conflictstatus (conflictstatus),
        .prioritystatus (prioritystatus),
        .busbusy        (busbusy),
        .owner          (owner)
    );

    always #5 clock = ~clock;

    // Packed as {flowvalve, conflictstatus, prioritystatus, busbusy, owner}.
    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got fv/cs/ps/bb/own=%h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic expect_idle(input string tag);
        check(tag, {flowvalve, conflictstatus, prioritystatus, busbusy, owner},
              {3'b000, 3'b000, 3'b000, 1'b0, 2'd3});
    endtask

    task automatic expect_grant(input string tag, input int idx, input bit urg);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        check(tag, {flowvalve, conflictstatus, prioritystatus, busbusy, owner},
              {oh, urg ? 3'b000 : oh, urg ? oh : 3'b000, 1'b1, 2'(idx)});
    endtask

    int rr_seq [4] = '{0, 1, 2, 0};

    initial begin
        reset   = 1'b1;
        request = 3'b000;
        urgent  = 3'b000;

        // Reset, then a single requester.
        tick(); tick();
        expect_idle("reset_state");
        reset   = 1'b0;
        request = 3'b001;
        tick();
        expect_grant("single_grant", 0, 1'b0);
        request = 3'b000;
        tick();
        expect_idle("single_turn");
        tick();
        expect_idle("single_idle");

        // Round-robin under full contention after a fresh reset.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        request = 3'b111;
        tick();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                expect_grant($sformatf("rr_r%0d_c%0d", r, c), rr_seq[r], 1'b0);
                tick();
            end
            expect_idle($sformatf("rr_turn%0d", r));
            if (r < 3) tick();
        end
        request = 3'b000;
        tick();
        expect_idle("rr_idle");

        // Urgent request preempts a normal owner.
        request = 3'b010;
        tick();
        expect_grant("pre_owner1", 1, 1'b0);
        request = 3'b011;
        urgent  = 3'b001;
        tick();
        expect_idle("pre_turn");
        tick();
        expect_grant("pre_urgent0", 0, 1'b1);

        // Urgent owner is not preempted, but times out at MAXHOLD.
        request = 3'b111;
        urgent  = 3'b111;
        for (int c = 2; c <= 4; c++) begin
            tick();
            expect_grant($sformatf("urg_hold%0d", c), 0, 1'b1);
        end
        tick();
        expect_idle("urg_timeout_turn");
        request = 3'b110;
        tick();
        expect_grant("urg_next1", 1, 1'b1);
        request = 3'b000;
        urgent  = 3'b000;
        tick();
        expect_idle("urg_release_turn");
        tick();
        expect_idle("urg_idle");

        // Uncontested owner holds past MAXHOLD with no turnaround.
        request = 3'b100;
        for (int c = 0; c < 12; c++) begin
            tick();
            expect_grant($sformatf("sat_c%0d", c), 2, 1'b0);
        end

        // Reset mid-grant, then urgent without request is ignored.
        reset = 1'b1;
        tick();
        expect_idle("reset_midgrant");
        reset   = 1'b0;
        request = 3'b000;
        urgent  = 3'b010;
        tick();
        expect_idle("urg_noreq_a");
        tick();
        expect_idle("urg_noreq_b");
        request = 3'b001;
        tick();
        expect_grant("post_reset_rr0", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
